cordic_engine: RTL and testbench
================================

// Module: cordic_engine
// PURPOSE
//  Parametrised iterative CORDIC engine; next generation of the fixed 2.16 rotator.
//  Adds vectoring mode (magnitude/atan2), full-circle quadrant pre-rotation, generic widths,
//  a runtime iteration count and a valid/ready handshake on both sides.
//  Serves both the sin/cos generator path and the polar-conversion path of the datapath.
// PARAMETERS
//  FRAC_W    16  fractional bits of x/y/z; x,y inputs are signed Q2.FRAC_W (DATA_W=FRAC_W+2)
//  ITER_MAX  16  maximum micro-rotations (1..FRAC_W); sizes the iteration counter
//  GUARD_W   2   extra MSBs on internal x/y to absorb CORDIC gain (1.6468) and sqrt(2) growth
// PORTS
//  clk        in   1                 rising-edge clock
//  rst_n      in   1                 asynchronous active-low reset
//  in_valid   in   1                 operand valid
//  in_ready   out  1                 engine can accept operands
//  mode       in   1                 0 = rotation (drive z to 0), 1 = vectoring (drive y to 0)
//  iter_cnt   in   clog2(ITER_MAX+1) iterations for this job; 0 or >ITER_MAX treated as ITER_MAX
//  x_in       in   FRAC_W+2          signed Q2.FRAC_W
//  y_in       in   FRAC_W+2          signed Q2.FRAC_W
//  z_in       in   FRAC_W+3          signed Q3.FRAC_W radians, legal range [-pi, +pi]
//  out_valid  out  1                 result valid
//  out_ready  in   1                 consumer accepts result
//  x_out      out  FRAC_W+2+GUARD_W  signed, uncompensated (scaled by K=1.64676)
//  y_out      out  FRAC_W+2+GUARD_W  signed, uncompensated
//  z_out      out  FRAC_W+3          signed Q3.FRAC_W radians
//  busy       out  1                 high in ITER state
// BEHAVIOUR
//  Reset: rst_n low -> state IDLE, counter 0, all x/y/z regs 0; out_valid=0, busy=0, in_ready=0
//   while rst_n low, in_ready=1 from first clk after release. Reset mid-job aborts it, no output.
//  FSM IDLE -> ITER -> DONE -> IDLE.
//   IDLE: in_ready=1. in_valid&in_ready at edge: latch mode/iter_cnt, apply pre-rotation, i=0, go ITER.
//   ITER: one micro-rotation per clk; after iteration N-1 go DONE. in_ready=0.
//   DONE: out_valid=1, outputs stable; on out_valid&out_ready -> IDLE (in_ready rises next clk).
//  Latency: accept edge to out_valid = N+1 clks; throughput one job per N+2 clks minimum.
//  Pre-rotation (accept cycle, sign-extended to internal width):
//   rotation:  z>+pi/2 -> x=-y, y=x, z=z-pi/2;  z<-pi/2 -> x=y, y=-x, z=z+pi/2; else pass
//   vectoring: x<0 & y>=0 -> x=y, y=-x, z=z+pi/2;  x<0 & y<0 -> x=-y, y=x, z=z-pi/2; else pass
//  Micro-rotation i: d=+1 if (rotation: z>=0 | vectoring: y<0) else -1
//   x'=x-d*(y>>>i); y'=y+d*(x>>>i); z'=z-d*atan(2^-i); all shifts arithmetic, truncating
//  Rotation gives x=K(x0cos z-y0sin z), y=K(y0cos z+x0sin z); caller loads x0=1/K for unit cos/sin
//   (FRAC_W=16: x0=0x09B75). Vectoring gives x=K*|v|, z=z0+atan2(y0,x0), y~0.
//  No saturation: internal width covers worst case; z wraps two's complement (cannot for legal in).
//  in_valid while not IDLE is ignored (no buffering); out_ready while not DONE is ignored.
//  iter_cnt/mode changes after accept do not affect the running job.
// STRUCTURE
//  cordic_pkg: FSM state typedef, PI_Q / HALF_PI_Q constants and function atan_q(i, FRAC_W)
//   returning round(atan(2^-i)*2^FRAC_W), table held to 30 fractional bits, truncated per FRAC_W.
//  Sub-module cordic_atan_rom: combinational index -> angle constant, instantiated once.
//  Engine: single iterative datapath (two barrel shifters, three add/sub), no unrolling.
// TESTING (FRAC_W=16, ITER_MAX=16, N=16, tolerance +-8 LSB unless stated)
//  Rotation x=39797,y=0,z=34315(pi/6) -> x_out~56756(cos), y_out~32768(sin), z_out~0, 17 clks
//  Rotation x=39797,y=0,z=-205887(-pi) -> pre-rotation taken; x_out~-65536, y_out~0
//  Vectoring x=65536,y=65536,z=0 -> z_out~51472(pi/4), x_out~152626, y_out~0
//  Vectoring x=-65536,y=-1,z=0 -> z_out~-205887 (approx -pi), x_out~107922; iter_cnt=4 gives done 5 clks
//  Handshake: hold out_ready=0 20 clks -> outputs stable, in_ready=0, new in_valid dropped;
//   then out_ready=1 -> IDLE next clk, back-to-back job spacing exactly N+2
//  rst_n pulsed low mid-ITER -> out_valid=0 immediately (async), outputs 0, next job exact

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared types and constants for the iterative CORDIC engine: FSM state encoding,
// pi constants and the arctangent table, all held at 30 fractional bits and rescaled per FRAC_W.
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam longint PI_Q      = 64'sd3373259426;
  localparam longint HALF_PI_Q = 64'sd1686629713;

  // Round a 30-fractional-bit constant to fw fractional bits.
  function automatic longint q_scale(input longint v30, input int fw);
    if (fw >= 30) return v30 <<< (fw - 30);
    return (v30 + (longint'(1) <<< (29 - fw))) >>> (30 - fw);
  endfunction

  function automatic longint atan_q(input int i, input int fw);
    longint t;
    case (i)
      0:  t = 64'sh3243F6A8;
      1:  t = 64'sh1DAC6705;
      2:  t = 64'sh0FADBAFC;
      3:  t = 64'sh07F56EA6;
      4:  t = 64'sh03FEAB76;
      5:  t = 64'sh01FFD55B;
      6:  t = 64'sh00FFFAAA;
      7:  t = 64'sh007FFF55;
      8:  t = 64'sh003FFFEA;
      9:  t = 64'sh001FFFFD;
      10: t = 64'sh000FFFFF;
      11: t = 64'sh0007FFFF;
      12: t = 64'sh0003FFFF;
      13: t = 64'sh0001FFFF;
      14: t = 64'sh0000FFFF;
      15: t = 64'sh00007FFF;
      16: t = 64'sh00003FFF;
      17: t = 64'sh00001FFF;
      18: t = 64'sh00000FFF;
      19: t = 64'sh000007FF;
      20: t = 64'sh000003FF;
      21: t = 64'sh000001FF;
      22: t = 64'sh000000FF;
      23: t = 64'sh0000007F;
      24: t = 64'sh0000003F;
      25: t = 64'sh0000001F;
      26: t = 64'sh0000000F;
      27: t = 64'sh00000008;
      28: t = 64'sh00000004;
      29: t = 64'sh00000002;
      30: t = 64'sh00000001;
      default: t = 64'sd0;
    endcase
    return q_scale(t, fw);
  endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational micro-rotation angle lookup: iteration index -> atan(2^-i) in Q3.FRAC_W.
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int FRAC_W   = 16,
  parameter int ITER_MAX = 16,
  parameter int Z_W      = FRAC_W + 3,
  parameter int CNT_W    = $clog2(ITER_MAX + 1)
) (
  input  logic [CNT_W-1:0]      idx_i,
  output logic signed [Z_W-1:0] angle_o
);

  always_comb begin
    angle_o = '0;
    for (int k = 0; k < ITER_MAX; k++) begin
      if (idx_i == CNT_W'(k)) angle_o = Z_W'(atan_q(k, FRAC_W));
    end
  end

endmodule

// File: rtl/cordic_engine.sv
// Iterative CORDIC engine (rotation and vectoring) with quadrant pre-rotation,
// runtime iteration count and valid/ready handshakes on both sides.
module cordic_engine
  import cordic_pkg::*;
#(
  parameter int  FRAC_W   = 16,
  parameter int  ITER_MAX = 16,
  parameter int  GUARD_W  = 2,
  localparam int DATA_W   = FRAC_W + 2,
  localparam int XY_W     = DATA_W + GUARD_W,
  localparam int Z_W      = FRAC_W + 3,
  localparam int CNT_W    = $clog2(ITER_MAX + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     mode,
  input  logic [CNT_W-1:0]         iter_cnt,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic signed [DATA_W-1:0] y_in,
  input  logic signed [Z_W-1:0]    z_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [XY_W-1:0]   x_out,
  output logic signed [XY_W-1:0]   y_out,
  output logic signed [Z_W-1:0]    z_out,
  output logic                     busy
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, and neither side buffers.

  localparam logic signed [Z_W-1:0] HALF_PI_Z = Z_W'(q_scale(HALF_PI_Q, FRAC_W));

  state_e                 state_q;
  logic                   mode_q;
  logic [CNT_W-1:0]       i_q;
  logic [CNT_W-1:0]       last_q;
  logic signed [XY_W-1:0] x_q, y_q;
  logic signed [Z_W-1:0]  z_q;
  logic                   in_ready_q, out_valid_q, busy_q;

  logic signed [XY_W-1:0] x_ext, y_ext, x_pre, y_pre;
  logic signed [Z_W-1:0]  z_pre;
  logic [CNT_W-1:0]       n_last;

  logic signed [XY_W-1:0] x_sh, y_sh, x_d, y_d;
  logic signed [Z_W-1:0]  atan_z, z_d;
  logic                   d_pos;

  assign x_ext = {{GUARD_W{x_in[DATA_W-1]}}, x_in};
  assign y_ext = {{GUARD_W{y_in[DATA_W-1]}}, y_in};

  assign n_last = ((iter_cnt == '0) || (iter_cnt > CNT_W'(ITER_MAX))) ?
                  CNT_W'(ITER_MAX - 1) : iter_cnt - CNT_W'(1);

  // Fold the operand into the right half-plane (vectoring) or |z| <= pi/2 (rotation).
  always_comb begin
    x_pre = x_ext;
    y_pre = y_ext;
    z_pre = z_in;
    if (!mode) begin
      if (z_in > HALF_PI_Z) begin
        x_pre = -y_ext;
        y_pre = x_ext;
        z_pre = z_in - HALF_PI_Z;
      end else if (z_in < -HALF_PI_Z) begin
        x_pre = y_ext;
        y_pre = -x_ext;
        z_pre = z_in + HALF_PI_Z;
      end
    end else if (x_ext[XY_W-1]) begin
      if (!y_ext[XY_W-1]) begin
        x_pre = y_ext;
        y_pre = -x_ext;
        z_pre = z_in + HALF_PI_Z;
      end else begin
        x_pre = -y_ext;
        y_pre = x_ext;
        z_pre = z_in - HALF_PI_Z;
      end
    end
  end

  cordic_atan_rom #(
    .FRAC_W   (FRAC_W),
    .ITER_MAX (ITER_MAX),
    .Z_W      (Z_W),
    .CNT_W    (CNT_W)
  ) u_atan_rom (
    .idx_i   (i_q),
    .angle_o (atan_z)
  );

  assign x_sh  = x_q >>> i_q;
  assign y_sh  = y_q >>> i_q;
  assign d_pos = mode_q ? y_q[XY_W-1] : ~z_q[Z_W-1];
  assign x_d   = d_pos ? (x_q - y_sh) : (x_q + y_sh);
  assign y_d   = d_pos ? (y_q + x_sh) : (y_q - x_sh);
  assign z_d   = d_pos ? (z_q - atan_z) : (z_q + atan_z);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= 1'b0;
      i_q         <= '0;
      last_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            mode_q     <= mode;
            last_q     <= n_last;
            i_q        <= '0;
            x_q        <= x_pre;
            y_q        <= y_pre;
            z_q        <= z_pre;
            state_q    <= ST_ITER;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ST_ITER: begin
          x_q <= x_d;
          y_q <= y_d;
          z_q <= z_d;
          if (i_q == last_q) begin
            state_q     <= ST_DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            i_q <= i_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign x_out     = x_q;
  assign y_out     = y_q;
  assign z_out     = z_q;

endmodule

// File: tb/tb_cordic_engine.sv
// Directed and randomised bench for cordic_engine at FRAC_W=16, ITER_MAX=16.
module tb_cordic_engine;

  localparam int  FRAC_W   = 16;
  localparam int  ITER_MAX = 16;
  localparam int  GUARD_W  = 2;
  localparam int  DATA_W   = FRAC_W + 2;
  localparam int  XY_W     = DATA_W + GUARD_W;
  localparam int  Z_W      = FRAC_W + 3;
  localparam int  CNT_W    = $clog2(ITER_MAX + 1);
  localparam real K_GAIN   = 1.6467602581210654;
  localparam real SCALE    = 65536.0;
  localparam int  N_LAT    = ITER_MAX + 1;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic                     mode = 1'b0;
  logic [CNT_W-1:0]         iter_cnt = '0;
  logic signed [DATA_W-1:0] x_in = '0;
  logic signed [DATA_W-1:0] y_in = '0;
  logic signed [Z_W-1:0]    z_in = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b1;
  logic signed [XY_W-1:0]   x_out, y_out;
  logic signed [Z_W-1:0]    z_out;
  logic                     busy;

  typedef struct {
    longint x;
    longint y;
    longint z;
    longint tol;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  cordic_engine #(
    .FRAC_W   (FRAC_W),
    .ITER_MAX (ITER_MAX),
    .GUARD_W  (GUARD_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .iter_cnt  (iter_cnt),
    .x_in      (x_in),
    .y_in      (y_in),
    .z_in      (z_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .y_out     (y_out),
    .z_out     (z_out),
    .busy      (busy)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // checks
  task automatic check_eq(input string tag, input longint obs, input longint expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_near(input string tag, input longint obs, input longint expv,
                            input longint tol);
    longint diff;
    diff = obs - expv;
    tests_run++;
    assert ((diff <= tol) && (diff >= -tol)) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d tol=%0d", tag, obs, expv, tol);
    end
  endtask

  // scoreboard
  task automatic push_exp(input longint ex, input longint ey, input longint ez, input longint tol);
    exp_t e;
    e.x = ex; e.y = ey; e.z = ez; e.tol = tol;
    exp_q.push_back(e);
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_scoreboard_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check_near({tag, "_x"}, longint'(x_out), e.x, e.tol);
      check_near({tag, "_y"}, longint'(y_out), e.y, e.tol);
      check_near({tag, "_z"}, longint'(z_out), e.z, e.tol);
    end
  endtask

  // drivers
  task automatic drive_fields(input logic m, input int n, input longint x, input longint y,
                              input longint z);
    mode     = m;
    iter_cnt = CNT_W'(n);
    x_in     = DATA_W'(x);
    y_in     = DATA_W'(y);
    z_in     = Z_W'(z);
  endtask

  // Returns at accept edge + #1 with in_valid dropped.
  task automatic send(input logic m, input int n, input longint x, input longint y,
                      input longint z);
    int g;
    g = 0;
    @(negedge clk);
    drive_fields(m, n, x, y, z);
    in_valid = 1'b1;
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    check_eq("accept_in_ready", longint'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts clocks from the accept edge (inclusive) until out_valid is seen.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_job(input string tag, input logic m, input int n, input longint x,
                         input longint y, input longint z, input longint ex, input longint ey,
                         input longint ez, input longint tol, input int exp_lat);
    int lat;
    push_exp(ex, ey, ez, tol);
    send(m, n, x, y, z);
    check_eq({tag, "_busy"}, longint'(busy), 1);
    wait_result(lat);
    check_eq({tag, "_latency"}, lat, exp_lat);
    pop_compare(tag);
    @(posedge clk);
    #1;
    check_eq({tag, "_idle_valid"}, longint'(out_valid), 0);
    check_eq({tag, "_idle_ready"}, longint'(in_ready), 1);
  endtask

  initial begin
    int     lat, sp, got_a, rdy;
    longint rz, vx, vy;
    real    rr, ang;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", longint'(in_ready), 0);
    check_eq("rst_out_valid", longint'(out_valid), 0);
    check_eq("rst_busy", longint'(busy), 0);
    check_eq("rst_x", longint'(x_out), 0);
    check_eq("rst_z", longint'(z_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rel_in_ready", longint'(in_ready), 1);

    // directed jobs
    run_job("rot_pi6", 1'b0, 16, 39797, 0, 34315, 56756, 32768, 0, 8, N_LAT);
    run_job("rot_mpi", 1'b0, 16, 39797, 0, -205887, -65536, 0, 0, 8, N_LAT);
    run_job("vec_q1", 1'b1, 16, 65536, 65536, 0, 152626, 0, 51472, 8, N_LAT);
    run_job("vec_q3", 1'b1, 16, -65536, -1, 0, 107922, 0, -205887, 8, N_LAT);

    // iteration count boundaries
    send(1'b1, 4, -65536, -1, 0);
    wait_result(lat);
    check_eq("iter4_latency", lat, 5);
    @(posedge clk);
    #1;
    check_eq("iter4_idle_ready", longint'(in_ready), 1);
    run_job("iter0", 1'b0, 0, 39797, 0, 34315, 56756, 32768, 0, 8, N_LAT);
    run_job("iter20", 1'b0, 20, 39797, 0, 34315, 56756, 32768, 0, 8, N_LAT);

    // random rotations over the full legal angle range
    for (int k = 0; k < 6; k++) begin
      rz  = longint'(int'($urandom_range(411774, 0))) - 205887;
      ang = real'(rz) / SCALE;
      run_job("rot_rand", 1'b0, 16, 39797, 0, rz,
              longint'(39797.0 * K_GAIN * $cos(ang)),
              longint'(39797.0 * K_GAIN * $sin(ang)), 0, 12, N_LAT);
    end

    // random vectoring, magnitude kept large so the angle is well resolved
    for (int k = 0; k < 6; k++) begin
      vx = longint'(int'($urandom_range(60000, 40000)));
      if ($urandom_range(1, 0) == 1) vx = -vx;
      vy = longint'(int'($urandom_range(120000, 0))) - 60000;
      rr = $sqrt(real'(vx) * real'(vx) + real'(vy) * real'(vy));
      run_job("vec_rand", 1'b1, 16, vx, vy, 0, longint'(K_GAIN * rr), 0,
              longint'($atan2(real'(vy), real'(vx)) * SCALE), 16, N_LAT);
    end

    // output back-pressure: result held, in_ready low, competing request dropped
    out_ready = 1'b0;
    push_exp(56756, 32768, 0, 8);
    send(1'b0, 16, 39797, 0, 34315);
    wait_result(lat);
    check_eq("hold_latency", lat, N_LAT);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      check_eq("hold_valid", longint'(out_valid), 1);
      check_eq("hold_in_ready", longint'(in_ready), 0);
      check_near("hold_x", longint'(x_out), 56756, 8);
      if (c == 4) begin
        drive_fields(1'b1, 16, 65536, 65536, 0);
        in_valid = 1'b1;
      end
      if (c == 15) in_valid = 1'b0;
    end
    pop_compare("hold");
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("release_valid", longint'(out_valid), 0);
    check_eq("release_ready", longint'(in_ready), 1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("dropped_busy", longint'(busy), 0);
    check_eq("dropped_valid", longint'(out_valid), 0);

    // back-to-back jobs; second changes mode/iter_cnt while the first runs
    push_exp(56756, 32768, 0, 8);
    push_exp(152626, 0, 51472, 8);
    @(negedge clk);
    drive_fields(1'b0, 16, 39797, 0, 34315);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    drive_fields(1'b1, 16, 65536, 65536, 0);
    sp = 0;
    got_a = 0;
    rdy = 0;
    while (rdy == 0 && sp < 100) begin
      @(negedge clk);
      rdy = int'(in_ready);
      if (out_valid) begin
        pop_compare("b2b_a");
        got_a = 1;
      end
      @(posedge clk);
      sp++;
    end
    #1 in_valid = 1'b0;
    check_eq("b2b_spacing", sp, ITER_MAX + 2);
    check_eq("b2b_a_seen", got_a, 1);
    wait_result(lat);
    check_eq("b2b_b_latency", lat, N_LAT);
    pop_compare("b2b_b");
    @(posedge clk);
    #1;

    // asynchronous reset in the middle of a job
    send(1'b0, 16, 39797, 0, 34315);
    repeat (5) @(posedge clk);
    #1;
    check_eq("mid_busy", longint'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_valid", longint'(out_valid), 0);
    check_eq("arst_busy", longint'(busy), 0);
    check_eq("arst_in_ready", longint'(in_ready), 0);
    check_eq("arst_x", longint'(x_out), 0);
    check_eq("arst_y", longint'(y_out), 0);
    check_eq("arst_z", longint'(z_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("arst_rel_ready", longint'(in_ready), 1);
    run_job("post_rst", 1'b0, 16, 39797, 0, 34315, 56756, 32768, 0, 8, N_LAT);

    check_eq("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
